// File: rtl/sdram_rddata.sv
// SDRAM read-data capture: waits out CAS latency after a read command, samples a
// fixed-length burst from DQ into a small valid/ready FIFO. Define SDRAM_RD_INREG_EN
// to insert an input capture flop on the DQ bus (sampling window moves one cycle later).
module sdram_rddata #(
  parameter int         CAS_LAT    = 3,
  parameter int         BURST_LEN  = 4,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [4:0] W_READ     = 5'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  work_st,
  input  logic [15:0] sdram_data,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        rd_last,
  output logic        rd_busy,
  output logic        rd_cmd_err,
  output logic        rd_ovf
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_CL, S_CAPT} state_t;

  logic [15:0] beat_data;

`ifdef SDRAM_RD_INREG_EN
  localparam int CAPT_START = CAS_LAT + 1;
  logic [15:0] din_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) din_q <= '0;
    else     din_q <= sdram_data;
  end
  assign beat_data = din_q;
`else
  localparam int CAPT_START = CAS_LAT;
  assign beat_data = sdram_data;
`endif

  // CAPT must begin in cycle CAPT_START; IDLE and CL account for cycles 0..CAPT_START-1.
  localparam logic [2:0]    LAT_LOAD  = 3'((CAPT_START >= 2) ? CAPT_START - 2 : 0);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  state_t          state_q;
  logic [2:0]      lat_q;
  logic [CW-1:0]   beat_q;
  logic            busy_q;
  logic            cmd_err_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lat_q     <= '0;
      beat_q    <= '0;
      busy_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (work_st == W_READ) begin
            busy_q <= 1'b1;
            beat_q <= '0;
            lat_q  <= LAT_LOAD;
            state_q <= (CAPT_START == 1) ? S_CAPT : S_CL;
          end
        end
        S_CL: begin
          if (lat_q == '0) begin
            state_q <= S_CAPT;
            beat_q  <= '0;
          end else begin
            lat_q <= lat_q - 3'd1;
          end
        end
        S_CAPT: begin
          if (beat_q == LAST_BEAT) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            beat_q <= beat_q + CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      if (state_q != S_IDLE && work_st == W_READ) cmd_err_q <= 1'b1;
    end
  end

  logic [16:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          capture, full, push, pop;

  assign capture = (state_q == S_CAPT);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = rd_valid & rd_ready;
  assign push    = capture & (~full | pop);

  // NOTE: storage array carries no reset; outputs are gated by rd_valid so stale contents never leak.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {(beat_q == LAST_BEAT), beat_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (capture && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign rd_valid   = (count_q != '0);
  assign rd_data    = rd_valid ? mem_q[rd_ptr_q][15:0] : 16'h0000;
  assign rd_last    = rd_valid & mem_q[rd_ptr_q][16];
  assign rd_busy    = busy_q;
  assign rd_cmd_err = cmd_err_q;
  assign rd_ovf     = ovf_q;

endmodule

// File: tb/tb_sdram_rddata.sv
// Scoreboard bench for sdram_rddata: bursts push expected {last,data} words into a
// queue; a negedge monitor pops and compares every word the consumer accepts.
module tb_sdram_rddata;

`ifdef SDRAM_RD_INREG_EN
  localparam int CL = 2;
  localparam int CS = CL + 1;
`else
  localparam int CL = 3;
  localparam int CS = CL;
`endif
  localparam int          BL     = 4;
  localparam logic [4:0]  W_READ = 5'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  work_st;
  logic [15:0] sdram_data;
  logic [15:0] rd_data;
  logic        rd_valid, rd_ready, rd_last, rd_busy, rd_cmd_err, rd_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];

  sdram_rddata #(.CAS_LAT(CL), .BURST_LEN(BL), .FIFO_DEPTH(8), .W_READ(W_READ)) dut (
    .clk(clk), .rst(rst), .work_st(work_st), .sdram_data(sdram_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .rd_busy(rd_busy), .rd_cmd_err(rd_cmd_err), .rd_ovf(rd_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_word: got %0h expected none (t=%0t)", {rd_last, rd_data}, $time);
      end else begin
        check("rd_word", {15'd0, rd_last, rd_data}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  // One read burst, cycle 0 = W_READ cycle; ends at the start of cycle CS+BL+1.
  task automatic run_burst(input logic [15:0] base, input bit push_exp, input int extra_cmd,
                           input int ready_from, input bit chk);
    if (push_exp)
      for (int i = 0; i < BL; i++) exp_q.push_back({(i == BL - 1), base + 16'(i)});
    for (int c = 0; c <= CS + BL; c++) begin
      work_st    = (c == 0 || c == extra_cmd) ? W_READ : 5'd0;
      sdram_data = (c >= CL && c < CL + BL) ? base + 16'(c - CL) : 16'hDEAD;
      rd_ready   = (c >= ready_from);
      if (chk) begin
        @(negedge clk);
        check($sformatf("busy_c%0d", c), rd_busy, (c >= 1 && c <= CS + BL - 1));
        check($sformatf("valid_c%0d", c), rd_valid, (c >= CS + 1 && c <= CS + BL));
      end
      @(posedge clk); #1;
    end
    work_st = 5'd0;
  endtask

  task automatic drain(input string name);
    rd_ready = 1'b1;
    work_st  = 5'd0;
    for (int i = 0; i < 64 && (exp_q.size() != 0 || rd_valid); i++) begin
      @(posedge clk); #1;
    end
    check({name, "_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_valid"}, rd_valid, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_data"}, rd_data, 16'h0);
    check({name, "_flags"}, {rd_valid, rd_last, rd_busy, rd_cmd_err, rd_ovf}, 5'b0);
  endtask

  initial begin
    rst = 1'b1; work_st = 5'd0; sdram_data = 16'h0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic burst with continuous ready: timing of busy/valid and data/last order.
    run_burst(16'hA000, 1'b1, -1, 0, 1'b1);
    drain("basic");

    // Second command while busy is ignored and flagged.
    run_burst(16'hB000, 1'b1, 2, 0, 1'b0);
    drain("cmd_err");
    check("cmd_err_set", rd_cmd_err, 1'b1);
    check("cmd_err_no_ovf", rd_ovf, 1'b0);

    // Reset in cycle 4 of a burst aborts it and clears everything.
    rd_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      work_st    = (c == 0) ? W_READ : 5'd0;
      sdram_data = (c >= CL) ? 16'h5000 + 16'(c - CL) : 16'hDEAD;
      @(posedge clk); #1;
    end
    work_st = 5'd0;
    check("pre_rst_valid", rd_valid, 1'b1);
    check("pre_rst_busy", rd_busy, 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_burst(16'h6000, 1'b1, -1, 0, 1'b1);
    drain("post_rst");

    // Full FIFO, then a burst whose beats coincide with pops: no overflow, order kept.
    run_burst(16'h7000, 1'b1, -1, 1000, 1'b0);
    run_burst(16'h8000, 1'b1, -1, 1000, 1'b0);
    check("full_hold_head", {15'd0, rd_last, rd_data}, 32'h7000);
    check("full_no_ovf", rd_ovf, 1'b0);
    run_burst(16'h9000, 1'b1, -1, CS, 1'b0);
    check("pushpop_no_ovf", rd_ovf, 1'b0);
    drain("pushpop");

    // Overflow: two bursts fill the FIFO, the third is dropped.
    run_burst(16'h1000, 1'b1, -1, 1000, 1'b0);
    run_burst(16'h2000, 1'b1, -1, 1000, 1'b0);
    check("ovf_before", rd_ovf, 1'b0);
    run_burst(16'h3000, 1'b0, -1, 1000, 1'b0);
    check("ovf_set", rd_ovf, 1'b1);
    check("ovf_head_kept", {15'd0, rd_last, rd_data}, 32'h1000);
    drain("ovf");
    check("ovf_sticky", rd_ovf, 1'b1);
    check("ovf_no_cmd_err", rd_cmd_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
